// File: rtl/pulse_run_controller.sv
// pulse_run_controller: run sequencer, double-buffered duration bank and delayed measurement strobe
module pulse_run_controller #(
    parameter int DUR_W       = 22,
    parameter int CNT_W       = 16,
    parameter int MEAS_DELAY  = 8,
    parameter int DEFAULT_DUR = 1000
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    input  logic                cfg_commit,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W-1:0]    repeat_count,
    input  logic                seq_start,
    input  logic                meas_level,
    output logic                pg_enable,
    output logic [16*DUR_W-1:0] pg_dur_flat,
    output logic                busy,
    output logic                done,
    output logic                meas_strobe,
    output logic [CNT_W-1:0]    meas_count,
    output logic                meas_overrun
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
    localparam int DLY_W = $clog2(MEAS_DELAY + 2);

    state_t state_q, state_d;
    logic [DUR_W-1:0] shadow_q [16];
    logic [DUR_W-1:0] active_q [16];
    logic [DUR_W-1:0] wval;
    logic [CNT_W-1:0] rep_q, rep_d, seq_cnt_q, seq_cnt_d, meas_count_q, meas_count_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic pending_q, pending_d, pg_enable_q, pg_enable_d, meas_prev_q;
    logic overrun_q, overrun_d, strobe_q, strobe_d;
    logic idle_like, start_ok, seq_last, copy, rise, fire;
    logic unused_wdata;

    assign unused_wdata = ^cfg_wdata[31:DUR_W];

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Run sequencing: abort dominates, start only honoured from IDLE/DONE
    always_comb begin
        state_d = state_q;
        if (abort) state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    state_d = start ? ARM : IDLE;
                ARM:     state_d = seq_start ? RUN : ARM;
                RUN:     state_d = seq_last ? DONE : RUN;
                DONE:    state_d = start ? ARM : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Status outputs and active bank flattening
    always_comb begin
        busy         = state_q == ARM || state_q == RUN;
        done         = state_q == DONE;
        pg_enable    = pg_enable_q;
        meas_strobe  = strobe_q;
        meas_count   = meas_count_q;
        meas_overrun = overrun_q;
        pg_dur_flat  = '0;
        for (int k = 0; k < 16; k++) pg_dur_flat[k*DUR_W +: DUR_W] = active_q[k];
    end

    // Next-state for run counters, commit handshake and measurement delay line
    always_comb begin
        wval         = cfg_wdata[DUR_W-1:0] == '0 ? DUR_W'(1) : cfg_wdata[DUR_W-1:0];
        idle_like    = state_q == IDLE || state_q == DONE;
        start_ok     = start && !abort && idle_like;
        seq_last     = state_q == RUN && seq_start && rep_q != '0 && seq_cnt_q == rep_q;
        copy         = pending_q && (idle_like || seq_start);
        rise         = meas_level && !meas_prev_q && state_q == RUN;
        fire         = dly_q == DLY_W'(1) || (rise && dly_q == '0 && MEAS_DELAY == 0);
        pending_d    = cfg_commit || (pending_q && !copy);
        rep_d        = start_ok ? repeat_count : rep_q;
        seq_cnt_d    = start_ok ? '0 :
                       (state_q == ARM && seq_start) ? CNT_W'(1) :
                       (state_q == RUN && seq_start && !seq_last) ? seq_cnt_q + CNT_W'(1) : seq_cnt_q;
        pg_enable_d  = state_d == ARM || state_d == RUN;
        dly_d        = abort ? '0 :
                       (rise && dly_q == '0) ? DLY_W'(MEAS_DELAY) :
                       dly_q != '0 ? dly_q - DLY_W'(1) : dly_q;
        strobe_d     = fire && !abort;
        meas_count_d = start_ok ? '0 :
                       (strobe_d && meas_count_q != '1) ? meas_count_q + CNT_W'(1) : meas_count_q;
        overrun_d    = start_ok ? 1'b0 : overrun_q || (rise && dly_q != '0);
    end

    // Shadow bank takes host writes; active bank copies it when a commit is released
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < 16; k++) begin
                shadow_q[k] <= DUR_W'(DEFAULT_DUR);
                active_q[k] <= DUR_W'(DEFAULT_DUR);
            end
        end else begin
            if (cfg_we) shadow_q[cfg_addr] <= wval;
            if (copy) active_q <= shadow_q;
        end
    end

    // Control and measurement registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pending_q    <= 1'b0;
            rep_q        <= '0;
            seq_cnt_q    <= '0;
            pg_enable_q  <= 1'b0;
            meas_prev_q  <= 1'b0;
            dly_q        <= '0;
            strobe_q     <= 1'b0;
            meas_count_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            rep_q        <= rep_d;
            seq_cnt_q    <= seq_cnt_d;
            pg_enable_q  <= pg_enable_d;
            meas_prev_q  <= meas_level;
            dly_q        <= dly_d;
            strobe_q     <= strobe_d;
            meas_count_q <= meas_count_d;
            overrun_q    <= overrun_d;
        end
    end
endmodule

// File: tb/tb_pulse_run_controller.sv
// tb_pulse_run_controller: randomized scenario bench for pulse_run_controller
module tb_pulse_run_controller;
    localparam int DUR_W = 22;
    localparam int CNT_W = 16;
    localparam int MEAS_DELAY = 8;
    localparam int DEFAULT_DUR = 1000;

    logic clk = 1'b0, rst = 1'b1;
    logic cfg_we = 1'b0, cfg_commit = 1'b0, start = 1'b0, abort = 1'b0;
    logic seq_start = 1'b0, meas_level = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [CNT_W-1:0] repeat_count = '0;
    logic pg_enable, busy, done, meas_strobe, meas_overrun;
    logic [16*DUR_W-1:0] pg_dur_flat;
    logic [CNT_W-1:0] meas_count;

    int checks = 0, passed = 0;
    logic [DUR_W-1:0] m_shadow [16];
    logic [DUR_W-1:0] m_active [16];

    pulse_run_controller #(.DUR_W(DUR_W), .CNT_W(CNT_W), .MEAS_DELAY(MEAS_DELAY), .DEFAULT_DUR(DEFAULT_DUR)) dut (
        .clk_in(clk), .rst_in(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .start(start), .abort(abort), .repeat_count(repeat_count),
        .seq_start(seq_start), .meas_level(meas_level), .pg_enable(pg_enable), .pg_dur_flat(pg_dur_flat),
        .busy(busy), .done(done), .meas_strobe(meas_strobe), .meas_count(meas_count),
        .meas_overrun(meas_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [16*DUR_W-1:0] model_flat();
        logic [16*DUR_W-1:0] f;
        for (int k = 0; k < 16; k++) f[k*DUR_W +: DUR_W] = m_active[k];
        return f;
    endfunction

    function automatic logic [DUR_W-1:0] stored(input logic [31:0] d);
        logic [DUR_W-1:0] t;
        t = d[DUR_W-1:0];
        return (t == 0) ? DUR_W'(1) : t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d, input logic commit);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d; cfg_commit = commit;
        m_shadow[a] = stored(d);
        tick();
        cfg_we = 1'b0; cfg_commit = 1'b0;
    endtask

    task automatic start_run(input logic [CNT_W-1:0] rep);
        repeat_count = rep; start = 1'b1;
        tick();
        start = 1'b0; seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 16; k++) begin
            m_shadow[k] = DUR_W'(DEFAULT_DUR);
            m_active[k] = DUR_W'(DEFAULT_DUR);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pg_dur_flat !== model_flat()) $display("FAIL reset_dur got=%0h exp=%0h", pg_dur_flat, model_flat());
        else passed++;
        checks++;
        if ({pg_enable, busy, done} !== 3'b000) $display("FAIL reset_ctl got=%b exp=000", {pg_enable, busy, done});
        else passed++;
        rst = 1'b0;
        tick();
        checks++;
        if ({meas_strobe, meas_overrun, meas_count} !== '0) $display("FAIL reset_meas got=%0h exp=0", {meas_strobe, meas_overrun, meas_count});
        else passed++;
        checks++;
        if ({pg_enable, busy, done} !== 3'b000) $display("FAIL post_reset_ctl got=%b exp=000", {pg_enable, busy, done});
        else passed++;
    endtask

    task automatic test_config();
        cfg_write(4'd3, 32'd0, 1'b0);
        cfg_write(4'd3, 32'd5, 1'b0);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        checks++;
        if (pg_dur_flat !== model_flat()) $display("FAIL commit_early got=%0h exp=%0h", pg_dur_flat, model_flat());
        else passed++;
        tick();
        m_active = m_shadow;
        checks++;
        if (pg_dur_flat[3*DUR_W +: DUR_W] !== DUR_W'(5)) $display("FAIL commit_entry3 got=%0d exp=5", pg_dur_flat[3*DUR_W +: DUR_W]);
        else passed++;
        cfg_write(4'd7, 32'd0, 1'b1);
        tick();
        m_active = m_shadow;
        checks++;
        if (pg_dur_flat[7*DUR_W +: DUR_W] !== DUR_W'(1)) $display("FAIL zero_to_one got=%0d exp=1", pg_dur_flat[7*DUR_W +: DUR_W]);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] d;
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d = d & 32'hFFC0_0000;
            cfg_write(4'($urandom_range(0, 15)), d, i == 7);
        end
        tick();
        m_active = m_shadow;
        checks++;
        if (pg_dur_flat !== model_flat()) $display("FAIL commit_random got=%0h exp=%0h", pg_dur_flat, model_flat());
        else passed++;
    endtask

    task automatic test_run();
        for (int t = 0; t < 3; t++) begin
            int rep;
            rep = (t == 0) ? 2 : int'($urandom_range(1, 5));
            repeat_count = CNT_W'(rep); start = 1'b1;
            tick();
            start = 1'b0; repeat_count = CNT_W'($urandom);
            checks++;
            if ({busy, pg_enable} !== 2'b11) $display("FAIL arm got=%b exp=11", {busy, pg_enable});
            else passed++;
            for (int n = 1; n <= rep + 1; n++) begin
                logic last;
                last = (n == rep + 1);
                seq_start = 1'b1; start = (n == 2);
                tick();
                seq_start = 1'b0; start = 1'b0;
                checks++;
                if ({done, pg_enable, busy} !== {last, ~last, ~last})
                    $display("FAIL seq%0d_of_%0d got=%b exp=%b", n, rep, {done, pg_enable, busy}, {last, ~last, ~last});
                else passed++;
                if (!last) repeat ($urandom_range(0, 3)) tick();
            end
            tick();
            checks++;
            if ({done, pg_enable, busy} !== 3'b000) $display("FAIL after_done got=%b exp=000", {done, pg_enable, busy});
            else passed++;
        end
        repeat_count = '0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            seq_start = 1'b1;
            tick();
            seq_start = 1'b0;
            checks++;
            if ({done, pg_enable, busy} !== 3'b011) $display("FAIL continuous%0d got=%b exp=011", n, {done, pg_enable, busy});
            else passed++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({done, pg_enable, busy} !== 3'b000) $display("FAIL abort_cont got=%b exp=000", {done, pg_enable, busy});
        else passed++;
    endtask

    task automatic test_meas();
        localparam int N = 80;
        logic pat [0:95];
        logic exp_s [0:95];
        logic prev, eover;
        int last, ecount;
        for (int i = 0; i < 96; i++) begin
            pat[i] = 1'b0;
            exp_s[i] = 1'b0;
        end
        pat[0] = 1'b1; pat[3] = 1'b1;
        for (int i = 12; i < N; i++) pat[i] = ($urandom_range(0, 3) == 0);
        prev = 1'b0; eover = 1'b0; last = -100; ecount = 0;
        for (int i = 0; i < N; i++) begin
            if (pat[i] && !prev) begin
                if (i - last >= MEAS_DELAY + 1) begin
                    exp_s[i + MEAS_DELAY + 1] = 1'b1;
                    last = i;
                    ecount++;
                end else eover = 1'b1;
            end
            prev = pat[i];
        end
        start_run('0);
        for (int i = 0; i < N + 12; i++) begin
            meas_level = pat[i];
            checks++;
            if (meas_strobe !== exp_s[i]) $display("FAIL strobe_cycle%0d got=%b exp=%b", i, meas_strobe, exp_s[i]);
            else passed++;
            if (i == 5) begin
                checks++;
                if (meas_overrun !== 1'b1) $display("FAIL overrun_early got=%b exp=1", meas_overrun);
                else passed++;
            end
            if (i == 9) begin
                checks++;
                if (meas_count !== CNT_W'(1)) $display("FAIL count_first got=%0d exp=1", meas_count);
                else passed++;
            end
            tick();
        end
        checks++;
        if (meas_count !== CNT_W'(ecount)) $display("FAIL count_total got=%0d exp=%0d", meas_count, ecount);
        else passed++;
        checks++;
        if (meas_overrun !== eover) $display("FAIL overrun_total got=%b exp=%b", meas_overrun, eover);
        else passed++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_commit_run();
        start_run('0);
        for (int i = 0; i < 4; i++) cfg_write(4'($urandom_range(0, 15)), $urandom, i == 3);
        repeat (4) tick();
        checks++;
        if (pg_dur_flat !== model_flat()) $display("FAIL commit_held got=%0h exp=%0h", pg_dur_flat, model_flat());
        else passed++;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        m_active = m_shadow;
        checks++;
        if (pg_dur_flat !== model_flat()) $display("FAIL commit_at_seq got=%0h exp=%0h", pg_dur_flat, model_flat());
        else passed++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_abort_start();
        logic seen;
        start_run(CNT_W'(3));
        meas_level = 1'b1;
        tick();
        meas_level = 1'b0;
        repeat (3) tick();
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        checks++;
        if ({done, pg_enable, busy} !== 3'b000) $display("FAIL abort_start got=%b exp=000", {done, pg_enable, busy});
        else passed++;
        seen = 1'b0;
        repeat (14) begin
            seen = seen | meas_strobe | done;
            tick();
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL abort_cancel got=%b exp=0", seen);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_config();
        test_run();
        test_meas();
        test_commit_run();
        test_abort_start();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
